// File: rtl/negate_rr_scheduler.sv
// Round-robin scheduler sharing one two's-complement negator among NREQ requesters.
// Results are held in a one-entry registered stage tagged with the requester ID.

module complement2s_8 (
    input  logic [7:0] i_a,
    output logic [7:0] o_y,
    output logic       o_ovf
);
    assign o_y   = ~i_a + 8'd1;
    assign o_ovf = (i_a == 8'h80);
endmodule

module negate_rr_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    output logic                    resp_valid,
    output logic [WIDTH-1:0]        resp_data,
    output logic [IDW-1:0]          resp_id,
    output logic                    resp_ovf,
    input  logic                    resp_ready,
    output logic [15:0]             busy_cnt,
    output logic                    dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; req_ready is combinational and one-hot on the granted index.

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;
    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

    logic [0:0]       r_state;
    logic [IDW-1:0]   r_ptr;
    logic [WIDTH-1:0] r_data;
    logic [IDW-1:0]   r_id;
    logic             r_ovf;
    logic [15:0]      r_busy;

    logic             w_can_issue;
    logic             w_any;
    logic             w_grant;
    logic [IDW-1:0]   w_gnt_idx;
    logic [IDW-1:0]   w_ptr_nxt;
    logic [WIDTH-1:0] w_operand;
    logic [WIDTH-1:0] w_neg;
    logic             w_ovf;

    assign w_can_issue = (r_state == ST_EMPTY) || ((r_state == ST_FULL) && resp_ready);
    assign w_grant     = w_can_issue && w_any;

    // Scan from the pointer upward; the explicit wrap keeps non-power-of-two NREQ in range.
    always_comb begin
        logic [IDW:0] v_sum;
        w_any     = 1'b0;
        w_gnt_idx = '0;
        v_sum     = '0;
        for (int i = 0; i < NREQ; i++) begin
            v_sum = {1'b0, r_ptr} + (IDW+1)'(i);
            if (v_sum >= NREQ_W) begin
                v_sum = v_sum - NREQ_W;
            end
            if (!w_any && req_valid[v_sum[IDW-1:0]]) begin
                w_any     = 1'b1;
                w_gnt_idx = v_sum[IDW-1:0];
            end
        end
    end

    always_comb begin
        logic [IDW:0] v_inc;
        v_inc = {1'b0, w_gnt_idx} + (IDW+1)'(1);
        if (v_inc >= NREQ_W) begin
            w_ptr_nxt = '0;
        end else begin
            w_ptr_nxt = v_inc[IDW-1:0];
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_grant) begin
            req_ready[w_gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        w_operand = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == w_gnt_idx) begin
                w_operand = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    generate
        if (WIDTH == 8) begin : g_c8
            complement2s_8 u_neg (
                .i_a   (w_operand),
                .o_y   (w_neg),
                .o_ovf (w_ovf)
            );
        end else begin : g_generic
            assign w_neg = ~w_operand + WIDTH'(1);
            assign w_ovf = (w_operand == {1'b1, {(WIDTH-1){1'b0}}});
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_ptr   <= '0;
            r_data  <= '0;
            r_id    <= '0;
            r_ovf   <= 1'b0;
        end else if (w_grant) begin
            r_state <= ST_FULL;
            r_ptr   <= w_ptr_nxt;
            r_data  <= w_neg;
            r_id    <= w_gnt_idx;
            r_ovf   <= w_ovf;
        end else if ((r_state == ST_FULL) && resp_ready) begin
            r_state <= ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else if ((|req_valid) && !w_can_issue && (r_busy != 16'hFFFF)) begin
            r_busy <= r_busy + 16'd1;
        end
    end

    assign resp_valid = (r_state == ST_FULL);
    assign resp_data  = r_data;
    assign resp_id    = r_id;
    assign resp_ovf   = r_ovf;
    assign busy_cnt   = r_busy;
    assign dbg_state  = r_state;

endmodule
